// File: rtl/mole_game_core.sv
// mole_game_core
//   Whack-a-mole game engine. A four-state FSM (IDLE, COUNTDOWN, PLAY, OVER)
//   is paced by an internal tick divider. Mole positions come from a 16-bit
//   LFSR, and hits come from buttons or the PC. A one-entry event register
//   feeds the UART TX formatter.
//
//   Optional feature macro: MISS_PENALTY_EN. When it is defined, a wrong
//   button during PLAY (with no valid hit in the same cycle) subtracts one
//   point, saturating at 0. When it is undefined, wrong buttons are ignored.
//
// Ports
//   clock, reset         system clock, synchronous active-high reset
//   start                1-cycle start pulse (button or PC 'S')
//   hit_btn[NUM_MOLES]   debounced 1-cycle button pulses
//   pc_hit               1-cycle PC hit pulse (PC 'H')
//   mole_led             one-hot active mole, 0 = no mole up
//   score                saturating score
//   time_left            remaining play ticks
//   countdown            pre-game countdown value, 0 outside COUNTDOWN
//   game_active          high in PLAY
//   game_over            high in OVER
//   evt_valid/evt_data   pending event byte {type[1:0],3'b000,idx[2:0]}
//   evt_ready            consumer accept
//   evt_drop             1-cycle pulse when a pending event was overwritten
//
// Event handshake: a byte transfers on a clock edge where evt_valid and
// evt_ready are both high. evt_valid stays high, with evt_data stable, until
// that transfer happens. The one exception is a new event: it overwrites the
// pending byte and pulses evt_drop if the old byte was not accepted in that
// same cycle.
module mole_game_core #(
  parameter int          NUM_MOLES    = 5,
  parameter int          SCORE_BITS   = 8,
  parameter int          GAME_SECONDS = 30,
  parameter int          TICK_DIV     = 100_000_000,
  parameter int          HOLD_TICKS   = 2,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NUM_MOLES-1:0]  hit_btn,
  input  logic                  pc_hit,
  output logic [NUM_MOLES-1:0]  mole_led,
  output logic [SCORE_BITS-1:0] score,
  output logic [5:0]            time_left,
  output logic [1:0]            countdown,
  output logic                  game_active,
  output logic                  game_over,
  output logic                  evt_valid,
  output logic [7:0]            evt_data,
  input  logic                  evt_ready,
  output logic                  evt_drop
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);
  localparam logic [5:0]    GAME_INIT = 6'(GAME_SECONDS);
  localparam logic [7:0]    NM8       = 8'(NUM_MOLES);
  localparam logic [2:0]    NM_LAST   = 3'(NUM_MOLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNTDOWN, S_PLAY, S_OVER} state_t;

  state_t                state_q, state_d;
  logic [TW-1:0]         tick_cnt;
  logic                  tick;
  logic [15:0]           lfsr_q;
  logic [HW-1:0]         hold_q, hold_d;
  logic [2:0]            prev_idx_q, prev_idx_d;
  logic [2:0]            raw_idx, spawn_idx;
  logic [NUM_MOLES-1:0]  spawn_onehot, mole_d;
  logic [SCORE_BITS-1:0] score_d;
  logic [5:0]            time_d;
  logic [1:0]            countdown_d;
  logic                  hit_any, do_spawn, ev_load;
  logic [7:0]            ev_byte;
`ifdef MISS_PENALTY_EN
  logic                  wrong_btn;
`endif

  assign tick        = (tick_cnt == TICK_LAST);
  assign game_active = (state_q == S_PLAY);
  assign game_over   = (state_q == S_OVER);

  // The divider restarts on every state change, so each phase begins with a full tick period.
  always_ff @(posedge clock) begin
    if (reset)                              tick_cnt <= '0;
    else if (tick || (state_d != state_q))  tick_cnt <= '0;
    else                                    tick_cnt <= tick_cnt + TW'(1);
  end

  // The LFSR (taps 16,14,13,11) free-runs every cycle, so mole placement depends on player timing.
  always_ff @(posedge clock) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // prev_idx_q holds the index of the most recently spawned mole. It is reset only
  // by reset, so the first mole of a new game also avoids the last mole of the previous game.
  always_comb begin
    raw_idx = 3'(lfsr_q[7:0] % NM8);
    if (raw_idx == prev_idx_q) spawn_idx = (raw_idx == NM_LAST) ? 3'd0 : raw_idx + 3'd1;
    else                       spawn_idx = raw_idx;
    spawn_onehot = '0;
    for (int i = 0; i < NUM_MOLES; i++) spawn_onehot[i] = (spawn_idx == 3'(i));
  end

  // A button and pc_hit arriving in the same cycle collapse into this single hit.
  assign hit_any = (state_q == S_PLAY) &&
                   (((hit_btn & mole_led) != '0) || (pc_hit && (mole_led != '0)));
`ifdef MISS_PENALTY_EN
  assign wrong_btn = (hit_btn & ~mole_led) != '0;
`endif

  always_comb begin
    state_d     = state_q;
    countdown_d = countdown;
    time_d      = time_left;
    score_d     = score;
    mole_d      = mole_led;
    hold_d      = hold_q;
    prev_idx_d  = prev_idx_q;
    do_spawn    = 1'b0;
    ev_load     = 1'b0;
    ev_byte     = 8'h00;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d     = S_COUNTDOWN;
          countdown_d = 2'd3;
          score_d     = '0;
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (countdown == 2'd1) begin
            state_d     = S_PLAY;
            countdown_d = 2'd0;
            time_d      = GAME_INIT;
            do_spawn    = 1'b1;
          end else begin
            countdown_d = countdown - 2'd1;
          end
        end
      end
      S_PLAY: begin
        // A hit is scored against the mole that is up now, even if a spawn replaces it this cycle.
        if (hit_any) begin
          if (score != '1) score_d = score + SCORE_BITS'(1);
          mole_d  = '0;
          ev_load = 1'b1;
          ev_byte = {2'b10, 3'b000, prev_idx_q};
        end
`ifdef MISS_PENALTY_EN
        else if (wrong_btn) begin
          if (score != '0) score_d = score - SCORE_BITS'(1);
        end
`endif
        if (tick) begin
          if (time_left == 6'd1) begin
            // The final tick ends the game and overrides any spawn due on the same tick.
            state_d = S_OVER;
            time_d  = 6'd0;
            mole_d  = '0;
            ev_load = 1'b1;
            ev_byte = 8'hC0;
          end else begin
            time_d = time_left - 6'd1;
            if (hold_q != '0) hold_d = hold_q - HW'(1);
            if ((hold_q == HW'(1)) || (mole_led == '0)) do_spawn = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (do_spawn) begin
      mole_d     = spawn_onehot;
      hold_d     = HOLD_INIT;
      prev_idx_d = spawn_idx;
      // A hit event in the same cycle takes precedence over the spawn event.
      if (!ev_load) begin
        ev_load = 1'b1;
        ev_byte = {2'b01, 3'b000, spawn_idx};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      countdown  <= '0;
      time_left  <= '0;
      score      <= '0;
      mole_led   <= '0;
      hold_q     <= '0;
      prev_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      countdown  <= countdown_d;
      time_left  <= time_d;
      score      <= score_d;
      mole_led   <= mole_d;
      hold_q     <= hold_d;
      prev_idx_q <= prev_idx_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_data  <= 8'h00;
      evt_drop  <= 1'b0;
    end else begin
      evt_drop <= 1'b0;
      if (ev_load) begin
        evt_valid <= 1'b1;
        evt_data  <= ev_byte;
        evt_drop  <= evt_valid && !evt_ready;
      end else if (evt_valid && evt_ready) begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule
